// File: rtl/gray_subtractor_pipe_if.sv
// Operand/result handshake bundle for the Gray-code subtractor pipeline.
// Carries the input valid/ready pair, both Gray operands, and the result channel.
// The master side drives operands and out_ready; the slave side is the subtractor.
interface gray_subtractor_pipe_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface

// File: rtl/gray_subtractor_pipe.sv
// Purpose: Gray-coded A-B with borrow flag; optional GRAY_SUB_ABS_EN gives |A-B| (sign-magnitude).
// Latency: 2 cycles (S1 Gray->binary decode, S2 subtract + binary->Gray encode), 1 pair/cycle.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; full pipe holds 2 pairs, outputs stable while stalled.
module gray_subtractor_pipe #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gray_subtractor_pipe_if.slave  bus,
    output logic                   busy
);

    // MSB-first Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        logic [N-1:0] g;
        g[N-1] = b[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_a_q, s1_b_q;
    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] diff_q, diff_d;
    logic         borrow_q, borrow_d;
    logic         s2_free, s1_adv, in_xfer;
    logic [N:0]   d_full;
    logic [N-1:0] mag;

    assign s2_free      = !s2_valid_q || bus.out_ready;
    assign s1_adv       = s1_valid_q && s2_free;
    assign bus.in_ready = !s1_valid_q || s2_free;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign busy          = s1_valid_q || s2_valid_q;

    // Stage-valid next state and the S2 arithmetic on the decoded operands.
    always_comb begin
        s1_valid_d = in_xfer || (s1_valid_q && !s1_adv);
        s2_valid_d = s1_adv || (s2_valid_q && !bus.out_ready);
        d_full     = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        borrow_d   = d_full[N];
`ifdef GRAY_SUB_ABS_EN
        // Negative result: re-subtract the other way so diff carries the magnitude.
        mag        = borrow_d ? (s1_b_q - s1_a_q) : d_full[N-1:0];
`else
        mag        = d_full[N-1:0];
`endif
        diff_d     = bin2gray(mag);
    end

    // Pipeline registers; data only moves on a transfer so stalled stages hold their contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_xfer) begin
                s1_a_q <= gray2bin(bus.in_a);
                s1_b_q <= gray2bin(bus.in_b);
            end
            if (s1_adv) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
            end
        end
    end

endmodule

// File: tb/tb_gray_subtractor_pipe.sv
// Directed bench for gray_subtractor_pipe with an in-order scoreboard on the result channel.
// Expected {borrow, diff} is computed from the Gray operands when an input transfer is seen.
// Build with +define+GRAY_SUB_ABS_EN to check the sign-magnitude variant.
module tb_gray_subtractor_pipe;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    gray_subtractor_pipe_if #(.N(N)) bus ();

    gray_subtractor_pipe #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;
    int outs  = 0;
    logic [N:0] q[$];
    logic [N:0] exp_r;

    // Reference: decode via reduction-XOR of the shifted Gray word, subtract, re-encode with g = b ^ (b>>1).
    function automatic logic [N:0] model(input logic [N-1:0] ga, input logic [N-1:0] gb);
        logic [N-1:0] ba, bb, m;
        logic         br;
        for (int i = 0; i < N; i++) begin
            ba[i] = ^(ga >> i);
            bb[i] = ^(gb >> i);
        end
        br = (ba < bb);
        m  = ba - bb;
`ifdef GRAY_SUB_ABS_EN
        if (br) m = bb - ba;
`endif
        return {br, m ^ (m >> 1)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sampled on the falling edge, so a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                total++;
                assert (q.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected observed diff=%b borrow=%b expected no result", bus.diff, bus.borrow);
                end
                if (q.size() > 0) begin
                    exp_r = q.pop_front();
                    total++;
                    assert ({bus.borrow, bus.diff} === exp_r) else begin
                        bad++;
                        $error("FAIL sb_result observed=%b_%b expected=%b_%b", bus.borrow, bus.diff, exp_r[N], exp_r[N-1:0]);
                    end
                    outs++;
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_a, bus.in_b));
        end
    end

    // One pair through an idle pipe with out_ready=1: invisible after 1 edge, valid after 2.
    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] ed, input logic eb, input string tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
        @(posedge clk); #1;
    endtask

    logic [N-1:0] bp_a [5] = '{4'b0001, 4'b0010, 4'b1111, 4'b0100, 4'b1010};
    logic [N-1:0] bp_b [5] = '{4'b0000, 4'b0111, 4'b0101, 4'b1100, 4'b0011};
    logic [N:0]   m0;
    int           idx;
    int           outs0;

    initial begin
        // Reset held 2 cycles while an operand is offered.
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'b1000;
        bus.in_b      = 4'b0000;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        run_one(4'b0110, 4'b0011, 4'b0011, 1'b0, "basic");
`ifdef GRAY_SUB_ABS_EN
        run_one(4'b0011, 4'b0110, 4'b0011, 1'b1, "underflow");
`else
        run_one(4'b0011, 4'b0110, 4'b1001, 1'b1, "underflow");
`endif
        run_one(4'b1000, 4'b0000, 4'b1000, 1'b0, "max_minus_zero");
        run_one(4'b0101, 4'b0101, 4'b0000, 1'b0, "equal");
        chk("idle_busy", 32'(busy), 32'd0);

        // Backpressure: fill the pipe with out_ready low, then release and drain at full rate.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = bp_a[i];
            bus.in_b     = bp_b[i];
            @(negedge clk);
            chk("bp_fill_in_ready", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_a = bp_a[2];
        bus.in_b = bp_b[2];
        m0 = model(bp_a[0], bp_b[0]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_full_busy", 32'(busy), 32'd1);
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stall_diff", 32'(bus.diff), 32'(m0[N-1:0]));
            chk("bp_stall_borrow", 32'(bus.borrow), 32'(m0[N]));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        outs0 = outs;
        idx   = 2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 5) begin
                bus.in_a = bp_a[idx];
                bus.in_b = bp_b[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bp_accepted", 32'(idx), 32'd5);
        chk("bp_drained_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_result_count", 32'(outs - outs0), 32'd5);
        @(posedge clk); #1;

        // Reset with two pairs in flight: both must vanish.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = bp_a[i+2];
            bus.in_b     = bp_b[i+2];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        outs0 = outs;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_no_stale", 32'(outs - outs0), 32'd0);
        chk("mid_valid_after", 32'(bus.out_valid), 32'd0);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_subtractor_pipe.md
Name: gray_subtractor_pipe

Overview:
- Pipelined N-bit Gray-code subtractor; the inverse-operation counterpart of the team's Gray-code adder.
- Accepts two Gray-coded operands over a valid/ready handshake and returns the Gray-coded difference A−B plus a borrow flag.
- Two registered stages: Gray-to-binary decode, then subtract with binary-to-Gray encode.
- Sits between Gray-coded pointer/counter sources and downstream consumers that need distances, e.g. FIFO occupancy from Gray pointers.

Parameters:
- N, 4, operand and difference width in bits; legal values are N ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  N  minuend, Gray code.
- in_b  input  N  subtrahend, Gray code.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- diff  output  N  Gray-coded difference.
- borrow  output  1  1 when bin(A) < bin(B).
- busy  output  1  either pipeline stage holds valid data.

Behaviour:
- Reset: rst_n sampled low at a rising clk edge clears both stage valid bits, diff, borrow and all stage data registers to 0.
  - Outputs after reset: out_valid=0, diff=0, borrow=0, busy=0.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-operation: any in-flight pairs are dropped silently; no partial result is presented.
- Input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): on input transfer, register bin(in_a) and bin(in_b).
  - Decode MSB-first: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i].
- Stage 2 (S2): on S1→S2 advance, compute D = binA − binB as an (N+1)-bit subtraction.
  - borrow = D[N].
  - diff = gray(D[N-1:0]): g[N-1]=b[N-1]; g[i]=b[i+1]^b[i].
  - diff and borrow are registered outputs.
- Latency: 2 cycles from input transfer to out_valid with no stalls. Throughput: 1 pair per cycle.
- Backpressure:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. It is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall: while out_valid=1 and out_ready=0, diff and borrow hold stable; S1 holds its data.
  - A full pipe deasserts in_ready.
  - Holding 2 pairs with no loss is the required full condition.
- Simultaneous events: on the same edge, an output transfer, an S1→S2 advance and a new input capture all occur. No bubble is inserted.
- Valid bits:
  - s2_valid next = s1_adv || (s2_valid && !out_ready).
  - s1_valid next = input transfer || (s1_valid && !s1_adv).
- Wrap-around: the difference is modulo 2^N; borrow flags the wrap.
- Equal operands give diff=0 and borrow=0.
- busy = s1_valid || s2_valid.
- No X propagation: when valid bits are 0, data registers keep their last values; those values are don't-care but never X after reset.

Optional Feature:
- Macro: GRAY_SUB_ABS_EN.
- Defined:
  - diff = gray(|bin(A)−bin(B)|); when borrow=1, S2 encodes (binB − binA).
  - borrow still reports A<B, so the pair {borrow, diff} is sign-magnitude.
  - Latency is unchanged.
- Undefined: diff is the modulo-2^N difference as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 2 cycles with in_valid=1, in_a=4'b1000 → out_valid=0, diff=0, borrow=0, busy=0; in_ready=1 the cycle after release.
- Basic (N=4): in_a=4'b0110 (4), in_b=4'b0011 (2), out_ready=1 → 2 cycles later out_valid=1, diff=4'b0011, borrow=0.
- Underflow: in_a=4'b0011 (2), in_b=4'b0110 (4) → diff=4'b1001 (14), borrow=1.
  - With GRAY_SUB_ABS_EN: diff=4'b0011, borrow=1.
- Boundaries: (in_a=4'b1000 (15), in_b=0) → diff=4'b1000, borrow=0. Equal operands (4'b0101, 4'b0101) → diff=0, borrow=0.
- Backpressure: stream 5 back-to-back pairs with out_ready=0 for cycles 2–6.
  - in_ready drops after 2 pairs are held.
  - diff holds stable during the stall.
  - After out_ready=1, all 5 results arrive in order, none lost or duplicated, at 1 per cycle.
- Reset mid-flight: 2 pairs in flight, assert rst_n=0 for 1 cycle → out_valid=0, busy=0, and no stale result appears afterwards.
